pipelined_alu: RTL and testbench

Parametrised, registered ALU of configurable width. It extends the team's 4-bit combinational add/sub/logic ALU with a valid/ready handshake on both sides, a multi-cycle shift-add multiplier, XOR, and a full status-flag set. It sits between an operand-issue stage and a result-writeback stage, and applies backpressure in both directions.

---
 rtl/pipelined_alu.sv | 207 ++++++++++++++++++++
 tb/tb_pipelined_alu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// ---------------------------------------------------------------------------
// pipelined_alu
//
// Registered ALU with a valid/ready handshake on both sides. Single-cycle
// operations (ADD, SUB, AND, OR, XOR, NOT, reserved) are computed and
// registered on the acceptance edge. MUL runs as a WIDTH-step LSB-first
// shift-add, followed by one edge that registers the product and its flags.
// Only one operation is ever in flight; there is no internal queue.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand bundle valid
//   in_ready   out  block can accept a bundle (combinational from out_ready)
//   op         in   3-bit operation code
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in, used by ADD only
//   out_valid  out  result bundle valid
//   out_ready  in   downstream accepts the result
//   result     out  low result word
//   result_hi  out  high product word for MUL, 0 otherwise
//   flag_c     out  carry / no-borrow / MUL high word nonzero
//   flag_z     out  zero
//   flag_n     out  result[WIDTH-1]
//   flag_v     out  signed overflow (ADD/SUB only)
//   flag_err   out  reserved opcode
// ---------------------------------------------------------------------------
module pipelined_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             flag_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Complete registered output bundle.
   typedef struct packed {
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] hi;
      logic             c;
      logic             z;
      logic             n;
      logic             v;
      logic             err;
   } res_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     count;
   logic                 accept;
   logic                 mul_last;
   res_t                 res_p1;

   logic [2*WIDTH-1:0]   prod_p;
   logic [2*WIDTH-1:0]   mcand_p;
   logic [WIDTH-1:0]     mplier_p;

   // Result and flags of every operation except MUL.
   function automatic res_t alu_single(
      input logic [2:0]       f_op,
      input logic [WIDTH-1:0] f_a,
      input logic [WIDTH-1:0] f_b,
      input logic             f_cin
   );
      res_t             r;
      logic [WIDTH:0]   sum;
      r   = '0;
      sum = '0;
      case (f_op)
         OP_ADD: begin
            sum  = {1'b0, f_a} + {1'b0, f_b} + {{WIDTH{1'b0}}, f_cin};
            r.lo = sum[WIDTH-1:0];
            r.c  = sum[WIDTH];
            // Same-sign operands producing an opposite-sign result.
            r.v  = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (r.lo[WIDTH-1] != f_a[WIDTH-1]);
         end
         OP_SUB: begin
            sum  = {1'b0, f_a} + {1'b0, ~f_b} + {{WIDTH{1'b0}}, 1'b1};
            r.lo = sum[WIDTH-1:0];
            // Carry out of a + ~b + 1 is the no-borrow indication (a >= b).
            r.c  = sum[WIDTH];
            r.v  = (f_a[WIDTH-1] != f_b[WIDTH-1]) && (r.lo[WIDTH-1] != f_a[WIDTH-1]);
         end
         OP_AND: r.lo = f_a & f_b;
         OP_OR:  r.lo = f_a | f_b;
         OP_XOR: r.lo = f_a ^ f_b;
         OP_NOT: r.lo = ~f_a;
         default: r.lo = '0;
      endcase
      if (f_op == OP_RSV) begin
         // Reserved code reports only the error flag; zero is not flagged.
         r.err = 1'b1;
      end else begin
         r.z = (r.lo == '0);
         r.n = r.lo[WIDTH-1];
      end
      return r;
   endfunction

   // Result and flags for a finished MUL.
   function automatic res_t mul_final(input logic [2*WIDTH-1:0] f_prod);
      res_t r;
      r    = '0;
      r.lo = f_prod[WIDTH-1:0];
      r.hi = f_prod[2*WIDTH-1:WIDTH];
      r.c  = (r.hi != '0);
      r.z  = (f_prod == '0);
      r.n  = r.lo[WIDTH-1];
      return r;
   endfunction

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign mul_last = (count == CNT_W'(WIDTH));

   assign out_valid = (state == DONE);
   assign result    = res_p1.lo;
   assign result_hi = res_p1.hi;
   assign flag_c    = res_p1.c;
   assign flag_z    = res_p1.z;
   assign flag_n    = res_p1.n;
   assign flag_v    = res_p1.v;
   assign flag_err  = res_p1.err;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = (op == OP_MUL) ? BUSY : DONE;
         end
         BUSY: begin
            if (mul_last) state_next = DONE;
         end
         DONE: begin
            if (out_ready) begin
               if (in_valid) state_next = (op == OP_MUL) ? BUSY : DONE;
               else          state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Stage p1: control state and registered output bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         res_p1 <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            count <= '0;
            if (op != OP_MUL) res_p1 <= alu_single(op, a, b, cin);
         end else if (state == BUSY) begin
            // WIDTH shift-add steps, then one edge to publish the product.
            if (mul_last) res_p1 <= mul_final(prod_p);
            else          count  <= count + 1'b1;
         end
      end
   end

   // Stage p0: multiplier datapath; only meaningful while BUSY, so no reset.
   always_ff @(posedge clk) begin
      if (accept && (op == OP_MUL)) begin
         mcand_p  <= {{WIDTH{1'b0}}, a};
         mplier_p <= b;
         prod_p   <= '0;
      end else if ((state == BUSY) && !mul_last) begin
         if (mplier_p[0]) prod_p <= prod_p + mcand_p;
         mcand_p  <= mcand_p << 1;
         mplier_p <= mplier_p >> 1;
      end
   end

endmodule

// File: tb/tb_pipelined_alu.sv
module tb_pipelined_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         flag_c, flag_z, flag_n, flag_v, flag_err;

   int n_chk  = 0;
   int n_fail = 0;

   // flg = {c, z, n, v, err}
   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] res;
      logic [7:0] hi;
      logic [4:0] flg;
   } vec_t;

   always #5 clk = ~clk;

   pipelined_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .result_hi(result_hi),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
      .flag_err(flag_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the opcode definitions.
   function automatic vec_t model(input logic [2:0] o, input logic [7:0] x,
                                  input logic [7:0] y, input logic c);
      vec_t e;
      int ux, uy, sx, sy, r, s;
      logic cf, zf, nf, vf, ef;
      ux = int'(x); uy = int'(y);
      sx = (ux > 127) ? ux - 256 : ux;
      sy = (uy > 127) ? uy - 256 : uy;
      e.op = o; e.a = x; e.b = y; e.cin = c;
      e.res = 8'h00; e.hi = 8'h00;
      cf = 1'b0; zf = 1'b0; nf = 1'b0; vf = 1'b0; ef = 1'b0;
      case (o)
         3'd0: begin
            r = ux + uy + int'(c); s = sx + sy + int'(c);
            e.res = 8'(r); cf = (r > 255); vf = (s > 127) || (s < -128);
         end
         3'd1: begin
            r = ux - uy; s = sx - sy;
            e.res = 8'(r); cf = (ux >= uy); vf = (s > 127) || (s < -128);
         end
         3'd2: e.res = x & y;
         3'd3: e.res = x | y;
         3'd4: e.res = x ^ y;
         3'd5: e.res = ~x;
         3'd6: begin
            r = ux * uy;
            e.res = 8'(r); e.hi = 8'(r / 256); cf = (r >= 256);
         end
         default: ef = 1'b1;
      endcase
      if (o == 3'd6)      zf = (ux * uy == 0);
      else if (o != 3'd7) zf = (e.res == 8'h00);
      if (o != 3'd7) nf = e.res[7];
      e.flg = {cf, zf, nf, vf, ef};
      return e;
   endfunction

   task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic c);
      int g;
      @(negedge clk);
      in_valid = 1'b1; op = o; a = x; b = y; cin = c;
      #1;
      g = 0;
      while (!in_ready && g < 100) begin
         @(negedge clk); #1; g++;
      end
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      // Scramble inputs after the edge; the DUT must have captured them.
      in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
   endtask

   task automatic collect(input string name, input vec_t e);
      int lat;
      int exp_lat;
      logic rdy_bad;
      lat = 0; rdy_bad = 1'b0;
      exp_lat = (e.op == 3'd6) ? W + 1 : 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) rdy_bad = 1'b1;
         @(posedge clk); #1; lat++;
      end
      check({name, ".latency"}, 32'(lat), 32'(exp_lat));
      check({name, ".ready_low_busy"}, 32'(rdy_bad), 32'd0);
      check({name, ".result"}, 32'(result), 32'(e.res));
      check({name, ".result_hi"}, 32'(result_hi), 32'(e.hi));
      check({name, ".flags"}, 32'({flag_c, flag_z, flag_n, flag_v, flag_err}), 32'(e.flg));
   endtask

   initial begin
      vec_t tv[$];
      vec_t e;
      vec_t adds[4];
      logic bad;

      tv.push_back('{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 5'b11000});
      tv.push_back('{3'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 5'b10010});
      tv.push_back('{3'd1, 8'h01, 8'h02, 1'b0, 8'hFF, 8'h00, 5'b00100});
      tv.push_back('{3'd6, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 5'b10000});
      tv.push_back('{3'd6, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 5'b01000});
      tv.push_back('{3'd4, 8'hA5, 8'h0F, 1'b0, 8'hAA, 8'h00, 5'b00100});
      tv.push_back('{3'd2, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 5'b00000});
      tv.push_back('{3'd3, 8'h50, 8'h0A, 1'b0, 8'h5A, 8'h00, 5'b00000});
      tv.push_back('{3'd5, 8'h0F, 8'hAA, 1'b0, 8'hF0, 8'h00, 5'b00100});
      tv.push_back('{3'd0, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 5'b00110});
      tv.push_back('{3'd1, 8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 5'b11000});
      tv.push_back('{3'd0, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 5'b11010});
      tv.push_back('{3'd7, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 5'b00001});
      tv.push_back('{3'd6, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 5'b10000});

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 3'd0; a = 8'h00; b = 8'h00; cin = 1'b0;
      #12;
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.result", 32'({result_hi, result}), 32'd0);
      check("reset.flags", 32'({flag_c, flag_z, flag_n, flag_v, flag_err}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < tv.size(); i++) begin
         send(tv[i].op, tv[i].a, tv[i].b, tv[i].cin);
         collect($sformatf("vec%0d", i), tv[i]);
      end

      // Backpressure: XOR held for 5 stalled cycles, then AND on the release edge
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(3'd4, 8'hA5, 8'h0F, 1'b0);
      collect("bp_xor", model(3'd4, 8'hA5, 8'h0F, 1'b0));
      in_valid = 1'b1; op = 3'd2; a = 8'hF0; b = 8'h3C; cin = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_stall%0d.in_ready", k), 32'(in_ready), 32'd0);
         check($sformatf("bp_stall%0d.out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp_stall%0d.result", k), 32'(result), 32'hAA);
         @(posedge clk); #1;
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("bp_release.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_and.out_valid", 32'(out_valid), 32'd1);
      check("bp_and.result", 32'(result), 32'h30);

      // Back-to-back ADDs with out_ready and in_valid held high
      adds[0] = model(3'd0, 8'h00, 8'h00, 1'b0);
      adds[1] = model(3'd0, 8'h10, 8'h20, 1'b0);
      adds[2] = model(3'd0, 8'hFF, 8'h02, 1'b0);
      adds[3] = model(3'd0, 8'h7F, 8'h7F, 1'b1);
      in_valid = 1'b1; op = adds[0].op; a = adds[0].a; b = adds[0].b; cin = adds[0].cin;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check($sformatf("b2b%0d.out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("b2b%0d.result", i), 32'(result), 32'(adds[i].res));
         check($sformatf("b2b%0d.flags", i), 32'({flag_c, flag_z, flag_n, flag_v, flag_err}), 32'(adds[i].flg));
         if (i < 3) begin
            op = adds[i+1].op; a = adds[i+1].a; b = adds[i+1].b; cin = adds[i+1].cin;
         end else begin
            in_valid = 1'b0;
         end
      end

      // Reset during MUL step 4: outputs clear immediately, no result afterwards
      send(3'd6, 8'hFF, 8'hFF, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mul_rst.out_valid", 32'(out_valid), 32'd0);
      check("mul_rst.result", 32'({result_hi, result}), 32'd0);
      check("mul_rst.flags", 32'({flag_c, flag_z, flag_n, flag_v, flag_err}), 32'd0);
      check("mul_rst.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         if (out_valid) bad = 1'b1;
      end
      check("mul_rst.no_result", 32'(bad), 32'd0);

      // Reserved op accepted on the first rising edge after reset release
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      in_valid = 1'b1; op = 3'd7; a = 8'h12; b = 8'h34; cin = 1'b1;
      #1;
      check("rsv.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect("rsv", model(3'd7, 8'h12, 8'h34, 1'b1));

      // Randomized operations against the reference model
      for (int i = 0; i < 120; i++) begin
         e = model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
         send(e.op, e.a, e.b, e.cin);
         collect($sformatf("rnd%0d_op%0d_%0h_%0h", i, e.op, e.a, e.b), e);
      end

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
